// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift receiver.
//   state_t   : receiver FSM state encoding (IDLE=0, RECV=1)
//   DIR_LEFT  : direction constant, first received bit lands in the MSB
//   DIR_RIGHT : direction constant, first received bit lands in the LSB
package shift_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Direction constants are 40 bits wide, which is wide enough to hold "RIGHT".
  // This width lets the two strings be compared directly.
  localparam logic [39:0] DIR_LEFT  = "LEFT";
  localparam logic [39:0] DIR_RIGHT = "RIGHT";

endpackage

// File: rtl/serial_shift_receiver.sv
// Serial-to-parallel word receiver with a frame marker.
//   clock     : rising-edge clock
//   Sclr      : synchronous active-high clear; has priority over everything
//   enable    : bit strobe; shift_in/frame are only looked at when high
//   shift_in  : serial data bit
//   frame     : strobed bit is the first bit of a word
//   q         : last completed word (held between valid pulses)
//   valid     : one-cycle pulse when q loads
//   busy      : a word is partially received
//   frame_err : one-cycle pulse when frame arrives mid-word (word restarts)
//   bit_count : bits received so far in the current word
module serial_shift_receiver
  import shift_pkg::*;
#(
  parameter int          SHIFT_WIDTH     = 8,
  parameter logic [39:0] SHIFT_DIRECTION = DIR_LEFT
) (
  input  logic                               clock,
  input  logic                               Sclr,
  input  logic                               enable,
  input  logic                               shift_in,
  input  logic                               frame,
  output logic [SHIFT_WIDTH-1:0]             q,
  output logic                               valid,
  output logic                               busy,
  output logic                               frame_err,
  output logic [$clog2(SHIFT_WIDTH+1)-1:0]   bit_count
);

  localparam int          CW      = $clog2(SHIFT_WIDTH+1);
  localparam bit          IS_LEFT = (SHIFT_DIRECTION == DIR_LEFT);
  localparam logic [CW-1:0] W_LAST = CW'(SHIFT_WIDTH - 1);

  state_t                 state, state_d;
  logic [SHIFT_WIDTH-1:0] asm_q, asm_d, q_d;
  logic [SHIFT_WIDTH-1:0] asm_shift, asm_first;
  logic [CW-1:0]          cnt_d;
  logic                   valid_d, ferr_d;

  // Restarting a word clears the stale partial bits. They would be shifted
  // out anyway, but clearing them keeps the register contents predictable.
  assign asm_shift = IS_LEFT ? {asm_q[SHIFT_WIDTH-2:0], shift_in}
                             : {shift_in, asm_q[SHIFT_WIDTH-1:1]};
  assign asm_first = IS_LEFT ? {{(SHIFT_WIDTH-1){1'b0}}, shift_in}
                             : {shift_in, {(SHIFT_WIDTH-1){1'b0}}};

  always_ff @(posedge clock) begin
    if (Sclr) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    asm_d   = asm_q;
    cnt_d   = bit_count;
    q_d     = q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (frame) begin
            asm_d   = asm_first;
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          if (frame) begin
            ferr_d = 1'b1;
            asm_d  = asm_first;
            cnt_d  = CW'(1);
          end else if (bit_count == W_LAST) begin
            // Last bit: q loads in the same edge, so valid appears one clock
            // after the final strobe and a frame strobe in that cycle is
            // accepted from IDLE without losing a bit.
            asm_d   = asm_shift;
            q_d     = asm_shift;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            asm_d = asm_shift;
            cnt_d = bit_count + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (Sclr) begin
      asm_q     <= '0;
      q         <= '0;
      bit_count <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      q         <= q_d;
      bit_count <= cnt_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_shift_receiver.sv
// Randomized self-checking bench: an LSB-first and an MSB-first receiver
// share one input stream and are compared every cycle against a bit-list model.
module tb_serial_shift_receiver;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clock = 1'b0;
  logic          Sclr, enable, shift_in, frame;
  logic [W-1:0]  q_l, q_r;
  logic          valid_l, valid_r, busy_l, busy_r, ferr_l, ferr_r;
  logic [CW-1:0] cnt_l, cnt_r;

  always #5 clock = ~clock;

  serial_shift_receiver #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION(DIR_LEFT)) u_left (
    .clock(clock), .Sclr(Sclr), .enable(enable), .shift_in(shift_in), .frame(frame),
    .q(q_l), .valid(valid_l), .busy(busy_l), .frame_err(ferr_l), .bit_count(cnt_l));

  serial_shift_receiver #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION(DIR_RIGHT)) u_right (
    .clock(clock), .Sclr(Sclr), .enable(enable), .shift_in(shift_in), .frame(frame),
    .q(q_r), .valid(valid_r), .busy(busy_r), .frame_err(ferr_r), .bit_count(cnt_r));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the list of bits received so far in the current word.
  bit          mbits[$];
  logic [W-1:0] mq_l = '0, mq_r = '0;
  bit          mvalid = 0, mferr = 0;
  int          cyc = 0;
  int          nvalid = 0, nferr = 0, last_valid_cyc = 0;

  task automatic model_edge();
    if (Sclr) begin
      mbits.delete(); mq_l = '0; mq_r = '0; mvalid = 0; mferr = 0;
    end else begin
      mvalid = 0; mferr = 0;
      if (enable) begin
        if (frame) begin
          if (mbits.size() > 0) mferr = 1;
          mbits.delete();
          mbits.push_back(shift_in);
        end else if (mbits.size() > 0) begin
          mbits.push_back(shift_in);
          if (mbits.size() == W) begin
            for (int i = 0; i < W; i++) begin
              mq_l[W-1-i] = mbits[i];
              mq_r[i]     = mbits[i];
            end
            mvalid = 1;
            mbits.delete();
          end
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit en, input bit fr, input bit b);
    @(negedge clock);
    Sclr = s; enable = en; frame = fr; shift_in = b;
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    chk("q_left",    q_l,     mq_l);
    chk("q_right",   q_r,     mq_r);
    chk("valid_l",   valid_l, mvalid);
    chk("valid_r",   valid_r, mvalid);
    chk("ferr_l",    ferr_l,  mferr);
    chk("ferr_r",    ferr_r,  mferr);
    chk("busy_l",    busy_l,  mbits.size() > 0);
    chk("busy_r",    busy_r,  mbits.size() > 0);
    chk("count_l",   cnt_l,   mbits.size());
    chk("count_r",   cnt_r,   mbits.size());
    chk("valid_and_ferr", valid_l & ferr_l, 1'b0);
    if (valid_l) begin nvalid++; last_valid_cyc = cyc; end
    if (ferr_l) nferr++;
  endtask

  // Sends bits MSB-first, with frame on the first bit and 0..maxgap idle
  // cycles before each bit after the first.
  task automatic send_word(input logic [W-1:0] w, input int maxgap, input bit chk_busy);
    for (int i = 0; i < W; i++) begin
      if (i > 0) begin
        int g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
        for (int k = 0; k < g; k++) begin
          step(0, 0, $urandom_range(1, 0), $urandom_range(1, 0));
          if (chk_busy) chk("busy_in_word", busy_l, 1'b1);
        end
      end
      step(0, 1, i == 0, w[W-1-i]);
      if (chk_busy && i < W-1) chk("busy_in_word", busy_l, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int v0, f0, c1;
    Sclr = 1; enable = 0; frame = 0; shift_in = 0;
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    chk("reset_q",     q_l,   '0);
    chk("reset_busy",  busy_l, 1'b0);
    chk("reset_count", cnt_l,  '0);

    // IDLE ignores unframed strobes
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1);
    chk("idle_ignore_busy", busy_l, 1'b0);

    // B2 MSB-first / 4D LSB-first
    v0 = nvalid;
    send_word(8'hB2, 0, 1);
    idle(3);
    chk("b2_left",  q_l, 8'hB2);
    chk("b2_right", q_r, 8'h4D);
    chk("b2_valid_once", nvalid - v0, 1);

    // random strobe gaps
    v0 = nvalid;
    send_word(8'hB2, 5, 1);
    idle(2);
    chk("gap_left", q_l, 8'hB2);
    chk("gap_valid_once", nvalid - v0, 1);

    // frame re-asserted after 3 bits
    v0 = nvalid; f0 = nferr;
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 0);
    send_word(8'h5A, 0, 0);
    idle(2);
    chk("reframe_ferr", nferr - f0, 1);
    chk("reframe_valid", nvalid - v0, 1);
    chk("reframe_q", q_l, 8'h5A);

    // Sclr mid-word
    v0 = nvalid; f0 = nferr;
    step(0, 1, 1, 0); for (int i = 0; i < 4; i++) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("sclr_busy", busy_l, 1'b0);
    chk("sclr_q", q_l, 8'h00);
    send_word(8'hC3, 0, 0);
    idle(2);
    chk("sclr_valid_once", nvalid - v0, 1);
    chk("sclr_no_ferr", nferr - f0, 0);
    chk("sclr_word", q_l, 8'hC3);

    // back-to-back FF then 00
    send_word(8'hFF, 0, 0);
    #0;
    chk("b2b_first_q", q_l, 8'hFF);
    chk("b2b_first_valid", valid_l, 1'b1);
    c1 = last_valid_cyc;
    send_word(8'h00, 0, 0);
    chk("b2b_second_q", q_l, 8'h00);
    chk("b2b_spacing", last_valid_cyc - c1, 8);
    idle(2);

    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(63, 0) == 0, $urandom_range(1, 0),
           $urandom_range(7, 0) == 0, $urandom_range(1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
